// File: rtl/dmem_bytelane.sv
// Byte-lane data memory for the MEM stage: byte/half/word loads and stores, 1-cycle registered read,
// post-reset clear sequencer. Optional macro DMEM_WRITE_FORWARD_EN forwards same-cycle store data to loads.
module dmem_bytelane #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFC00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        misalign,
  output logic        range_err
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [32:0]     WIN_BYTES = 33'(DEPTH) << 2;
  localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset_p0;
  logic            in_range_p0, misal_p0, err_p0, active_p0, req_p0, we_p0;
  logic [AW-1:0]   idx_p0;
  logic [1:0]      lane_p0;
  logic [3:0]      be_p0;
  logic [31:0]     wd_p0, old_p0, merged_p0, src_p0;

  logic [31:0]     rdata_p1;
  logic            vld_p1, mis_p1, rng_p1;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'b0, b} : 32'(b);
      2'b01:   load_ext = uns ? {16'b0, h} : 32'(h);
      default: load_ext = w;
    endcase
  endfunction

  // Stage p0: address decode, lane enables and store merge
  assign offset_p0   = addr - BASE_ADDR;
  assign in_range_p0 = (addr >= BASE_ADDR) && ({1'b0, offset_p0} < WIN_BYTES);
  assign idx_p0      = offset_p0[AW+1:2];
  assign lane_p0     = addr[1:0];
  assign active_p0   = (state_q == IDLE);
  assign req_p0      = active_p0 & (mem_read | mem_write);
  assign err_p0      = misal_p0 | ~in_range_p0;
  assign we_p0       = active_p0 & mem_write & ~err_p0;
  assign old_p0      = mem[idx_p0];

  always_comb begin
    misal_p0 = 1'b0;
    be_p0    = 4'b0000;
    wd_p0    = wdata;
    case (size)
      2'b00: begin
        be_p0 = 4'b0001 << lane_p0;
        wd_p0 = {4{wdata[7:0]}};
      end
      2'b01: begin
        misal_p0 = lane_p0[0];
        be_p0    = lane_p0[1] ? 4'b1100 : 4'b0011;
        wd_p0    = {2{wdata[15:0]}};
      end
      2'b10: begin
        misal_p0 = (lane_p0 != 2'b00);
        be_p0    = 4'b1111;
      end
      default: misal_p0 = 1'b1;
    endcase
  end

  always_comb begin
    merged_p0 = old_p0;
    for (int b = 0; b < 4; b++)
      if (be_p0[b]) merged_p0[8*b +: 8] = wd_p0[8*b +: 8];
  end

`ifdef DMEM_WRITE_FORWARD_EN
  assign src_p0 = we_p0 ? merged_p0 : old_p0;
`else
  assign src_p0 = old_p0;
`endif

  // Clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_cnt_q == LAST_IDX) state_d = IDLE;
  end

  // The array has no reset; the sequencer owns the write port while clearing.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[clr_cnt_q] <= '0;
    else if (we_p0)       mem[idx_p0]    <= merged_p0;
  end

  // Stage p1: registered load result and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      rng_p1   <= 1'b0;
    end else begin
      vld_p1 <= active_p0 & mem_read;
      mis_p1 <= req_p0 & misal_p0;
      rng_p1 <= req_p0 & ~in_range_p0;
      if (active_p0 & mem_read)
        rdata_p1 <= err_p0 ? '0 : load_ext(src_p0, size, lane_p0, unsigned_ld);
    end
  end

  assign rdata     = rdata_p1;
  assign rvalid    = vld_p1;
  assign misalign  = mis_p1;
  assign range_err = rng_p1;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed steps plus random traffic against a byte-level reference model.
module tb_dmem_bytelane;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'hFFFFFC00;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, busy, misalign, range_err;

  always #5 clk = ~clk;

  dmem_bytelane dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .busy(busy), .misalign(misalign), .range_err(range_err)
  );

  int          n_cmp = 0, n_fail = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata = '0;
  logic        exp_rvalid, exp_mis, exp_rng;
  bit          stray;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed window arithmetic with masks and shifts.
  task automatic model(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    longint unsigned la, lb;
    bit              inr, mis;
    int              idx, lane;
    logic [31:0]     old, nw, src, v, mask;
    la   = a;
    lb   = BASE;
    inr  = (la >= lb) && (la < lb + 4 * DEPTH);
    lane = int'(a % 4);
    mis  = (sz == 2'd3) || (sz == 2'd1 && lane % 2 == 1) || (sz == 2'd2 && lane != 0);
    idx  = inr ? int'((la - lb) / 4) : 0;
    old  = ref_mem[idx];
    nw   = old;
    if (wr && inr && !mis) begin
      case (sz)
        2'd0: begin mask = 32'hFF << (8 * lane);   nw = (old & ~mask) | ((wd & 32'hFF) << (8 * lane));   end
        2'd1: begin mask = 32'hFFFF << (8 * lane); nw = (old & ~mask) | ((wd & 32'hFFFF) << (8 * lane)); end
        default: nw = wd;
      endcase
    end
    src = old;
`ifdef DMEM_WRITE_FORWARD_EN
    src = nw;
`endif
    exp_rvalid = rd;
    exp_mis    = (rd || wr) && mis;
    exp_rng    = (rd || wr) && !inr;
    if (rd) begin
      if (mis || !inr) exp_rdata = '0;
      else begin
        v = src >> (8 * lane);
        case (sz)
          2'd0: begin v = v & 32'hFF;   if (!uns && v[7])  v = v | 32'hFFFFFF00; end
          2'd1: begin v = v & 32'hFFFF; if (!uns && v[15]) v = v | 32'hFFFF0000; end
          default: v = src;
        endcase
        exp_rdata = v;
      end
    end
    ref_mem[idx] = nw;
  endtask

  // Issue one request at posedge+1, check the outputs it produces one edge later.
  task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    model(rd, wr, sz, uns, a, wd);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    chk("rvalid", rvalid, exp_rvalid);
    chk("rdata", rdata, exp_rdata);
    chk("misalign", misalign, exp_mis);
    chk("range_err", range_err, exp_rng);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (rvalid || misalign || range_err) stray = 1'b1;
    end while (busy && n < 1000);
  endtask

  task automatic model_cleared();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_rdata = '0;
  endtask

  initial begin
    int          n;
    logic [31:0] exp_b [4];
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          r, c;

    exp_b[0] = 32'hFFFFFFBB; exp_b[1] = 32'hFFFFFFAA; exp_b[2] = 32'hFFFFFF99; exp_b[3] = 32'hFFFFFF88;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_range_err", range_err, 1'b0);
    chk("rst_busy", busy, 1'b1);

    // Clear sequence with requests held active throughout
    mem_read = 1'b1; mem_write = 1'b1; size = 2'd2; addr = BASE; wdata = 32'hFFFFFFFF;
    stray = 1'b0;
    rst_n = 1'b1;
    wait_clear(n);
    mem_read = 1'b0; mem_write = 1'b0;
    chk("clear_cycles", n, 256);
    chk("clear_quiet", stray, 1'b0);
    model_cleared();

    req(1, 0, 2'd2, 0, BASE, 0);
    chk("cleared_word0", rdata, 32'h0);

    // Lane stores and extended loads
    req(0, 1, 2'd2, 0, 32'hFFFFFC10, 32'h8899AABB);
    for (int i = 0; i < 4; i++) begin
      req(1, 0, 2'd0, 0, 32'hFFFFFC10 + i, 0);
      chk("ld_byte_signed", rdata, exp_b[i]);
    end
    req(1, 0, 2'd0, 1, 32'hFFFFFC10, 0);
    chk("ld_byte_unsigned", rdata, 32'h000000BB);
    req(0, 1, 2'd0, 0, 32'hFFFFFC11, 32'h0000005A);
    req(1, 0, 2'd2, 0, 32'hFFFFFC10, 0);
    chk("st_byte_merge", rdata, 32'h88995ABB);
    req(0, 1, 2'd1, 0, 32'hFFFFFC12, 32'h00001234);
    req(1, 0, 2'd2, 0, 32'hFFFFFC10, 0);
    chk("st_half_merge", rdata, 32'h12345ABB);
    req(1, 0, 2'd1, 0, 32'hFFFFFC12, 0);
    chk("ld_half", rdata, 32'h00001234);

    // Error cases
    req(0, 1, 2'd2, 0, 32'hFFFFFC02, 32'hCAFEF00D);
    chk("mis_word_pulse", misalign, 1'b1);
    req(1, 0, 2'd2, 0, BASE, 0);
    chk("mis_store_suppressed", rdata, 32'h0);
    req(1, 0, 2'd2, 0, 32'h00000000, 0);
    chk("range_pulse", range_err, 1'b1);
    chk("range_rvalid", rvalid, 1'b1);
    chk("range_rdata", rdata, 32'h0);
    req(1, 0, 2'd3, 0, 32'hFFFFFC10, 0);
    chk("mis_size11", misalign, 1'b1);

    // Same-cycle store and load
    req(1, 1, 2'd2, 0, 32'hFFFFFC20, 32'hDEADBEEF);
`ifdef DMEM_WRITE_FORWARD_EN
    chk("rw_same_cycle", rdata, 32'hDEADBEEF);
`else
    chk("rw_same_cycle", rdata, 32'h0);
`endif

    // Random traffic, back-to-back, biased toward a small hot window and the window edges
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      c  = $urandom_range(0, 9);
      if (c < 7)       a = BASE + $urandom_range(0, 63);
      else if (c == 7) a = BASE + $urandom_range(0, 1023);
      else if (c == 8) a = $urandom;
      else             a = ($urandom_range(0, 1) != 0) ? BASE - $urandom_range(1, 4)
                                                       : 32'hFFFFFFFC + $urandom_range(0, 3);
      if (c < 5) a = a & ((sz == 2'd2) ? 32'hFFFFFFFC : (sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
      wd = $urandom;
      req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd);
    end

    // Reset pulse in the middle of a clear restarts it
    req(0, 1, 2'd2, 0, 32'hFFFFFFFC, 32'hA5A55A5A);
    req(1, 0, 2'd2, 0, 32'hFFFFFFFC, 0);
    chk("last_word_written", rdata, 32'hA5A55A5A);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midclear_busy", busy, 1'b1);
    chk("midclear_rdata", rdata, 32'h0);
    stray = 1'b0;
    rst_n = 1'b1;
    wait_clear(n);
    chk("restart_cycles", n, 256);
    chk("restart_quiet", stray, 1'b0);
    model_cleared();
    req(1, 0, 2'd2, 0, 32'hFFFFFFFC, 0);
    chk("last_word_cleared", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor to the single-port data memory, sitting in the MEM stage of the pipelined MIPS core.
- Supports byte, half-word and word loads and stores, with little-endian lane selection.
- Load results are sign- or zero-extended and returned through a registered read with 1-cycle latency.
- A post-reset clear sequencer zeroes the array; range and misalignment errors are flagged.

Parameters:
- DEPTH, 256: number of 32-bit words, power of two, at least 4.
- BASE_ADDR, 32'hFFFFFC00: byte address of word 0; must be 4-byte aligned.
- AW, $clog2(DEPTH): internal word-index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request, sampled at posedge.
- mem_write  in  1  store request, sampled at posedge.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  in  1  1 selects zero-extension for byte/half loads; 0 selects sign-extension.
- addr  in  32  byte address.
- wdata  in  32  store data; the byte is in [7:0], the half in [15:0].
- rdata  out  32  extended load result.
- rvalid  out  1  1-cycle pulse when rdata is updated.
- busy  out  1  high while the clear sequencer runs.
- misalign  out  1  1-cycle pulse: previous request was misaligned or used a reserved size.
- range_err  out  1  1-cycle pulse: previous request's address was outside the memory window.

Behaviour:
- Reset (async, while rst_n=0):
  - rdata=0, rvalid=0, misalign=0, range_err=0, busy=1.
  - FSM=CLEAR, clear counter=0.
  - The array itself has no reset.
- FSM CLEAR:
  - Each cycle writes 0 to word[counter], then counter+1.
  - After word DEPTH-1 is written, go to IDLE and drop busy on the following edge.
  - Total clear time is DEPTH cycles after rst_n rises.
  - mem_read and mem_write are ignored; no rvalid or error pulses.
  - Reset asserted mid-clear restarts the counter at 0.
- FSM IDLE: services requests; IDLE is never left except by reset.
- Decode:
  - in_range = addr >= BASE_ADDR and addr < BASE_ADDR + 4*DEPTH.
  - Word index = (addr - BASE_ADDR) >> 2; lane = addr[1:0].
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size=11 with any address.
- Store (mem_write=1, in range, aligned):
  - Byte: wdata[7:0] goes to bits [8*lane+7 : 8*lane].
  - Half: wdata[15:0] goes to [15:0] if lane=0, or to [31:16] if lane=2.
  - Word: the full word is written.
  - Other lanes are unchanged.
- Load (mem_read=1): the next cycle delivers rvalid=1 and rdata.
  - Byte/half: the selected lane, shifted to bit 0 and extended per unsigned_ld.
  - Word: the raw word.
  - rdata holds its value between loads.
- Errors:
  - Either error on a request suppresses the store (array unchanged).
  - A load with an error still pulses rvalid, with rdata=0.
  - misalign and range_err pulse in the cycle after the request; both may be set together.
- Simultaneous mem_read and mem_write, same cycle:
  - The store is performed.
  - The load returns pre-store contents (read-before-write), unless the optional feature is enabled.
- Back-to-back requests: accepted every cycle, with no stall.

Optional Feature:
- Macro: DMEM_WRITE_FORWARD_EN.
- Defined: a load issued in the same cycle as a valid store to the same word returns the merged post-store word, then extracts and extends from it. Other lanes come from the old contents.
- Undefined: read-before-write as described above.
- Error-suppressed stores never forward in either case.

Test Plan:
- Reset, then count cycles → busy=1 for exactly 256 cycles. A load at 32'hFFFFFC00 issued during busy → no rvalid. After busy falls, a load of word FFFFFC00 → 0.
- Word store 32'h8899AABB at FFFFFC10, then byte loads at FFFFFC10..13 → signed loads return FFFFFFBB, FFFFFFAA, FFFFFF99, FFFFFF88; with unsigned_ld=1 → 000000BB.
- Byte store 8'h5A at FFFFFC11, then word load → 8899_5ABB. Half store 16'h1234 at FFFFFC12, then word load → 1234_5ABB. A half load at FFFFFC12 → 00001234.
- Word store at FFFFFC02 → misalign pulse and memory unchanged. A load at 32'h00000000 → range_err=1, rvalid=1, rdata=0. size=11 → misalign pulse.
- Same-cycle store of 32'hDEADBEEF and load to FFFFFC20 (old value 0) → rdata=0 without the macro, DEADBEEF with DMEM_WRITE_FORWARD_EN.
- Pulse rst_n low for 1 cycle at clear count 100 → busy stays high for 256 further cycles, and the last word (FFFFFFFC) reads 0.
